// File: rtl/cache_refill_arbiter.sv
// Arbitrates icache/dcache line refills onto one AXI4 read channel, one burst at a time.
// Build option ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: dcache priority).
module cache_refill_arbiter #(
    parameter int unsigned BURST_LEN = 8,
    parameter logic [3:0]  ICACHE_ID = 4'd0,
    parameter logic [3:0]  DCACHE_ID = 4'd1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rd_req,
    input  logic [31:0]             i_rd_addr,
    output logic                    i_ret_valid,
    output logic [BURST_LEN*32-1:0] i_ret_data,
    input  logic                    d_rd_req,
    input  logic [31:0]             d_rd_addr,
    output logic                    d_ret_valid,
    output logic [BURST_LEN*32-1:0] d_ret_data,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [3:0]              arid,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    input  logic [1:0]              rresp,
    input  logic [3:0]              rid,
    output logic                    bus_err
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned LINE_W     = DATA_W * BURST_LEN;
    localparam int unsigned CNT_W      = $clog2(BURST_LEN);
    localparam int unsigned LINE_BYTES = LINE_W / 8;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [7:0]        AR_LEN    = 8'(BURST_LEN - 1);
    localparam logic [2:0]        AR_SIZE   = 3'b010;
    localparam logic [1:0]        AR_BURST  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic                           r_gnt_d;
    logic                           w_gnt_d_nxt;
    logic [ADDR_W-1:0]              r_addr;
    logic [ADDR_W-1:0]              w_addr_nxt;
    logic [BURST_LEN-1:0][DATA_W-1:0] r_buf;
    logic [BURST_LEN-1:0][DATA_W-1:0] w_buf_nxt;
    logic [LINE_W-1:0]              w_line_nxt;
    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               w_cnt_nxt;
    logic                           r_err;
    logic                           w_err_nxt;

    logic                           r_arvalid;
    logic [ADDR_W-1:0]              r_araddr;
    logic [7:0]                     r_arlen;
    logic [2:0]                     r_arsize;
    logic [1:0]                     r_arburst;
    logic [ID_W-1:0]                r_arid;
    logic                           r_rready;
    logic                           r_i_ret_valid;
    logic                           r_d_ret_valid;
    logic [LINE_W-1:0]              r_i_ret_data;
    logic [LINE_W-1:0]              r_d_ret_data;
    logic                           r_bus_err;

    logic                           w_arvalid_nxt;
    logic [ADDR_W-1:0]              w_araddr_nxt;
    logic [7:0]                     w_arlen_nxt;
    logic [2:0]                     w_arsize_nxt;
    logic [1:0]                     w_arburst_nxt;
    logic [ID_W-1:0]                w_arid_nxt;
    logic                           w_rready_nxt;
    logic                           w_ret_fire;
    logic                           w_i_ret_valid_nxt;
    logic                           w_d_ret_valid_nxt;
    logic [LINE_W-1:0]              w_i_ret_data_nxt;
    logic [LINE_W-1:0]              w_d_ret_data_nxt;
    logic                           w_bus_err_nxt;

    logic                           w_req_any;
    logic                           w_pick_d;
    logic [ID_W-1:0]                w_gnt_id;
    logic                           w_ar_hs;
    logic                           w_beat_ok;
    logic                           w_beat_last;

    assign w_req_any   = i_rd_req | d_rd_req;
    assign w_gnt_id    = r_gnt_d ? DCACHE_ID : ICACHE_ID;
    assign w_ar_hs     = r_arvalid & arready;
    assign w_beat_ok   = r_rready & rvalid & (rid == w_gnt_id);
    assign w_beat_last = w_beat_ok & (rlast | (r_cnt == LAST_BEAT));
    assign w_line_nxt  = w_buf_nxt;

`ifdef ROUND_ROBIN_EN
    // Pointer names the requester that wins the next tie; it moves past every grant.
    logic r_ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr_d <= 1'b0;
        end else if (r_state == S_IDLE && w_req_any) begin
            r_ptr_d <= ~w_pick_d;
        end
    end

    assign w_pick_d = d_rd_req & (~i_rd_req | r_ptr_d);
`else
    assign w_pick_d = d_rd_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RET always falls back to IDLE so a held request is re-arbitrated, never re-granted in RET.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any)   w_state_nxt = S_ADDR;
            S_ADDR:  if (w_ar_hs)     w_state_nxt = S_DATA;
            S_DATA:  if (w_beat_last) w_state_nxt = S_RET;
            S_RET:                    w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Grant/address latch and line assembly; beats with a foreign rid are dropped.
    always_comb begin
        w_gnt_d_nxt = r_gnt_d;
        w_addr_nxt  = r_addr;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_gnt_d_nxt = w_pick_d;
                    w_addr_nxt  = w_pick_d ? d_rd_addr : i_rd_addr;
                end
            end
            S_ADDR: begin
                if (w_ar_hs) begin
                    w_buf_nxt = '0;
                    w_cnt_nxt = '0;
                    w_err_nxt = 1'b0;
                end
            end
            S_DATA: begin
                if (w_beat_ok) begin
                    w_buf_nxt[r_cnt] = rdata;
                    w_cnt_nxt        = r_cnt + CNT_W'(1);
                    w_err_nxt        = r_err | (rresp inside {2'b10, 2'b11});
                end
            end
            default: ;
        endcase
    end

    // Output decode from the next state so every port comes straight off a flop.
    always_comb begin
        w_arvalid_nxt     = (w_state_nxt == S_ADDR);
        w_araddr_nxt      = '0;
        w_arlen_nxt       = '0;
        w_arsize_nxt      = '0;
        w_arburst_nxt     = '0;
        w_arid_nxt        = '0;
        if (w_arvalid_nxt) begin
            w_araddr_nxt  = w_addr_nxt & LINE_MASK;
            w_arlen_nxt   = AR_LEN;
            w_arsize_nxt  = AR_SIZE;
            w_arburst_nxt = AR_BURST;
            w_arid_nxt    = w_gnt_d_nxt ? DCACHE_ID : ICACHE_ID;
        end
        w_rready_nxt      = (w_state_nxt == S_DATA);
        w_ret_fire        = (w_state_nxt == S_RET);
        w_i_ret_valid_nxt = w_ret_fire & ~r_gnt_d;
        w_d_ret_valid_nxt = w_ret_fire & r_gnt_d;
        w_bus_err_nxt     = w_ret_fire & w_err_nxt;
        w_i_ret_data_nxt  = w_i_ret_valid_nxt ? w_line_nxt : r_i_ret_data;
        w_d_ret_data_nxt  = w_d_ret_valid_nxt ? w_line_nxt : r_d_ret_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_d <= 1'b0;
            r_addr  <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_gnt_d <= w_gnt_d_nxt;
            r_addr  <= w_addr_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arsize      <= '0;
            r_arburst     <= '0;
            r_arid        <= '0;
            r_rready      <= 1'b0;
            r_i_ret_valid <= 1'b0;
            r_d_ret_valid <= 1'b0;
            r_i_ret_data  <= '0;
            r_d_ret_data  <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            r_arvalid     <= w_arvalid_nxt;
            r_araddr      <= w_araddr_nxt;
            r_arlen       <= w_arlen_nxt;
            r_arsize      <= w_arsize_nxt;
            r_arburst     <= w_arburst_nxt;
            r_arid        <= w_arid_nxt;
            r_rready      <= w_rready_nxt;
            r_i_ret_valid <= w_i_ret_valid_nxt;
            r_d_ret_valid <= w_d_ret_valid_nxt;
            r_i_ret_data  <= w_i_ret_data_nxt;
            r_d_ret_data  <= w_d_ret_data_nxt;
            r_bus_err     <= w_bus_err_nxt;
        end
    end

    assign arvalid     = r_arvalid;
    assign araddr      = r_araddr;
    assign arlen       = r_arlen;
    assign arsize      = r_arsize;
    assign arburst     = r_arburst;
    assign arid        = r_arid;
    assign rready      = r_rready;
    assign i_ret_valid = r_i_ret_valid;
    assign d_ret_valid = r_d_ret_valid;
    assign i_ret_data  = r_i_ret_data;
    assign d_ret_data  = r_d_ret_data;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: refills, arbitration order, early rlast, errors, reset.
module tb_cache_refill_arbiter;

`ifdef ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd_req, d_rd_req;
    logic [31:0]  i_rd_addr, d_rd_addr;
    logic         i_ret_valid, d_ret_valid;
    logic [255:0] i_ret_data, d_ret_data;
    logic         arvalid, arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arid;
    logic         rvalid, rready, rlast;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic [3:0]   rid;
    logic         bus_err;

    int n_vec = 0;
    int n_err = 0;

    cache_refill_arbiter dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rlast(rlast), .rresp(rresp), .rid(rid), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input bit ok, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] base, input int n);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < n; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic wait_ar(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_id);
        int c;
        c = 0;
        while (arvalid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk({tag, "_arvalid"}, (arvalid === 1'b1), 256'(arvalid), 256'(1'b1));
        chk({tag, "_araddr"}, (araddr === exp_addr), 256'(araddr), 256'(exp_addr));
        chk({tag, "_arid"}, (arid === exp_id), 256'(arid), 256'(exp_id));
        chk({tag, "_arfields"}, ({arlen, arsize, arburst} === {8'd7, 3'b010, 2'b01}),
            256'({arlen, arsize, arburst}), 256'({8'd7, 3'b010, 2'b01}));
        chk({tag, "_rready_in_addr"}, (rready === 1'b0), 256'(rready), 256'(1'b0));
    endtask

    // Presents n beats; bad_at inserts a foreign-rid beat (with rlast and SLVERR) before beat bad_at.
    task automatic send_beats(input string tag, input int n, input logic [31:0] base, input logic [3:0] id,
                              input int rlast_at, input int err_at, input int bad_at);
        tick();
        chk({tag, "_rready"}, (rready === 1'b1), 256'(rready), 256'(1'b1));
        for (int k = 0; k < n; k++) begin
            if (k == bad_at) begin
                rvalid = 1'b1; rid = id ^ 4'h1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b10;
                tick();
            end
            rvalid = 1'b1;
            rid    = id;
            rdata  = base + 32'(k);
            rlast  = (k == rlast_at);
            rresp  = (k == err_at) ? 2'b10 : 2'b00;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    endtask

    task automatic check_ret(input string tag, input bit is_d, input logic [255:0] line, input bit err);
        logic [255:0] got;
        got = is_d ? d_ret_data : i_ret_data;
        chk({tag, "_i_ret_valid"}, (i_ret_valid === !is_d), 256'(i_ret_valid), 256'(!is_d));
        chk({tag, "_d_ret_valid"}, (d_ret_valid === is_d), 256'(d_ret_valid), 256'(is_d));
        chk({tag, "_bus_err"}, (bus_err === err), 256'(bus_err), 256'(err));
        chk({tag, "_ret_data"}, (got === line), got, line);
        chk({tag, "_rready_in_ret"}, (rready === 1'b0), 256'(rready), 256'(1'b0));
    endtask

    task automatic post_ret(input string tag, input bit is_d, input logic [255:0] line);
        logic [255:0] got;
        tick();
        got = is_d ? d_ret_data : i_ret_data;
        chk({tag, "_pulse_end"}, ({i_ret_valid, d_ret_valid, bus_err} === 3'b000),
            256'({i_ret_valid, d_ret_valid, bus_err}), 256'(3'b000));
        chk({tag, "_no_regrant_in_ret"}, (arvalid === 1'b0), 256'(arvalid), 256'(1'b0));
        chk({tag, "_data_held"}, (got === line), got, line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_d;
        reset = 1'b0;
        i_rd_req = 1'b0; i_rd_addr = '0; d_rd_req = 1'b0; d_rd_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = '0; rid = '0;
        tick(); tick();
        chk("rst_outputs", ({arvalid, rready, i_ret_valid, d_ret_valid, bus_err} === 5'b0),
            256'({arvalid, rready, i_ret_valid, d_ret_valid, bus_err}), 256'(5'b0));
        chk("rst_araddr", ({araddr, arlen, arsize, arburst, arid} === 49'b0),
            256'({araddr, arlen, arsize, arburst, arid}), 256'(49'b0));
        chk("rst_i_ret_data", (i_ret_data === 256'b0), i_ret_data, 256'b0);
        chk("rst_d_ret_data", (d_ret_data === 256'b0), d_ret_data, 256'b0);
        reset = 1'b1;
        arready = 1'b1;
        tick();

        // icache-only miss, unaligned address
        i_rd_req = 1'b1; i_rd_addr = 32'h1C00_0044;
        tick();
        chk("t1_latency", (arvalid === 1'b1), 256'(arvalid), 256'(1'b1));
        wait_ar("t1", 32'h1C00_0040, 4'd0);
        send_beats("t1", 8, 32'h0, 4'd0, 7, -1, -1);
        check_ret("t1", 1'b0, line_of(32'h0, 8), 1'b0);
        i_rd_req = 1'b0;
        post_ret("t1", 1'b0, line_of(32'h0, 8));

        // simultaneous requests: dcache first, icache after, dcache re-requests mid icache burst
        i_rd_req = 1'b1; i_rd_addr = 32'h2000_0000;
        d_rd_req = 1'b1; d_rd_addr = 32'h3000_0024;
        wait_ar("t2d", 32'h3000_0020, 4'd1);
        send_beats("t2d", 8, 32'h100, 4'd1, 7, -1, -1);
        check_ret("t2d", 1'b1, line_of(32'h100, 8), 1'b0);
        d_rd_req = 1'b0;
        post_ret("t2d", 1'b1, line_of(32'h100, 8));
        wait_ar("t2i", 32'h2000_0000, 4'd0);
        d_rd_req = 1'b1; d_rd_addr = 32'h3000_0040;
        send_beats("t2i", 8, 32'h200, 4'd0, 7, -1, -1);
        chk("t2i_no_second_ar", (arvalid === 1'b0), 256'(arvalid), 256'(1'b0));
        check_ret("t2i", 1'b0, line_of(32'h200, 8), 1'b0);
        i_rd_req = 1'b0;
        post_ret("t2i", 1'b0, line_of(32'h200, 8));
        wait_ar("t2d2", 32'h3000_0040, 4'd1);
        send_beats("t2d2", 8, 32'h280, 4'd1, 7, -1, -1);
        check_ret("t2d2", 1'b1, line_of(32'h280, 8), 1'b0);
        d_rd_req = 1'b0;
        post_ret("t2d2", 1'b1, line_of(32'h280, 8));

        // reset restores the tie pointer to icache; four refills with both requests held
        reset = 1'b0;
        tick();
        chk("t3_rst_data", ({i_ret_data, d_ret_data} === 512'b0), i_ret_data | d_ret_data, 256'b0);
        reset = 1'b1;
        tick();
        i_rd_req = 1'b1; i_rd_addr = 32'h4000_0000;
        d_rd_req = 1'b1; d_rd_addr = 32'h5000_0000;
        for (int r = 0; r < 4; r++) begin
            exp_d = RR_EN ? (r % 2 == 1) : 1'b1;
            wait_ar($sformatf("t3_%0d", r), exp_d ? 32'h5000_0000 : 32'h4000_0000, exp_d ? 4'd1 : 4'd0);
            send_beats($sformatf("t3_%0d", r), 8, 32'h300 + 32'(r * 16), exp_d ? 4'd1 : 4'd0, 7, -1, -1);
            check_ret($sformatf("t3_%0d", r), exp_d, line_of(32'h300 + 32'(r * 16), 8), 1'b0);
            if (r == 3) begin
                i_rd_req = 1'b0;
                d_rd_req = 1'b0;
            end
            post_ret($sformatf("t3_%0d", r), exp_d, line_of(32'h300 + 32'(r * 16), 8));
        end

        // early rlast on beat 3: upper words must read zero
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_1234;
        wait_ar("t4", 32'h0000_1220, 4'd0);
        send_beats("t4", 4, 32'h400, 4'd0, 3, -1, -1);
        check_ret("t4", 1'b0, line_of(32'h400, 4), 1'b0);
        i_rd_req = 1'b0;
        post_ret("t4", 1'b0, line_of(32'h400, 4));
        tick();
        chk("t4_idle", ({arvalid, rready} === 2'b00), 256'({arvalid, rready}), 256'(2'b00));

        // arready stall, then SLVERR on beat 5
        arready = 1'b0;
        d_rd_req = 1'b1; d_rd_addr = 32'h6000_00FC;
        wait_ar("t5", 32'h6000_00E0, 4'd1);
        tick();
        chk("t5_stall_hold", ({arvalid, araddr, arid} === {1'b1, 32'h6000_00E0, 4'd1}),
            256'({arvalid, araddr, arid}), 256'({1'b1, 32'h6000_00E0, 4'd1}));
        tick();
        chk("t5_stall_rready", (rready === 1'b0), 256'(rready), 256'(1'b0));
        arready = 1'b1;
        send_beats("t5", 8, 32'h500, 4'd1, 7, 5, -1);
        check_ret("t5", 1'b1, line_of(32'h500, 8), 1'b1);
        d_rd_req = 1'b0;
        post_ret("t5", 1'b1, line_of(32'h500, 8));

        // foreign-rid beat in the middle is ignored, even with rlast and an error response
        d_rd_req = 1'b1; d_rd_addr = 32'h7000_0000;
        wait_ar("t6", 32'h7000_0000, 4'd1);
        send_beats("t6", 8, 32'h600, 4'd1, 7, -1, 2);
        check_ret("t6", 1'b1, line_of(32'h600, 8), 1'b0);
        d_rd_req = 1'b0;
        post_ret("t6", 1'b1, line_of(32'h600, 8));

        // reset after four beats abandons the burst; a fresh request then completes
        i_rd_req = 1'b1; i_rd_addr = 32'h8000_0010;
        wait_ar("t7", 32'h8000_0000, 4'd0);
        send_beats("t7", 4, 32'h650, 4'd0, -1, -1, -1);
        reset = 1'b0;
        #1;
        chk("t7_rst_async", ({arvalid, rready, i_ret_valid, d_ret_valid, bus_err} === 5'b0),
            256'({arvalid, rready, i_ret_valid, d_ret_valid, bus_err}), 256'(5'b0));
        i_rd_req = 1'b0;
        tick(); tick();
        chk("t7_rst_no_ret", ({i_ret_valid, d_ret_valid, bus_err} === 3'b000),
            256'({i_ret_valid, d_ret_valid, bus_err}), 256'(3'b000));
        chk("t7_rst_data", (i_ret_data === 256'b0), i_ret_data, 256'b0);
        reset = 1'b1;
        tick();
        chk("t7_release_idle", ({arvalid, rready} === 2'b00), 256'({arvalid, rready}), 256'(2'b00));
        d_rd_req = 1'b1; d_rd_addr = 32'h9000_0000;
        wait_ar("t7n", 32'h9000_0000, 4'd1);
        send_beats("t7n", 8, 32'h700, 4'd1, 7, -1, -1);
        check_ret("t7n", 1'b1, line_of(32'h700, 8), 1'b0);
        d_rd_req = 1'b0;
        post_ret("t7n", 1'b1, line_of(32'h700, 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
